ap_accumulator: RTL and testbench
=================================

Name: ap_accumulator

Overview:
- Sequential, parametrised successor to the combinational saturating adder.
- Accumulates a stream of TERMS signed operands into one saturating sum, using the same clamp-to-±INF overflow rule at every step.
- Used for RBM hidden/visible unit activation sums (weight·state partial products) ahead of the sigmoid/sampling stage.
- Valid/ready handshake on both sides; one result per TERMS accepted operands.

Parameters:
- BITLENGTH, 12, operand/accumulator/result width (signed two's complement).
- INF, 2^(BITLENGTH-1)-1 (12'b0111_1111_1111 at default), positive clamp value; the negative clamp is -INF.
- TERMS, 16, operands per sum; legal range ≥1; counter width is $clog2(TERMS) with a minimum of 1.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- clear, input, 1, synchronous abort of the current sum.
- in_valid, input, 1, operand valid.
- in_ready, output, 1, block can accept an operand.
- in_data, input, BITLENGTH signed, operand.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts result.
- out_data, output, BITLENGTH signed, accumulated saturated sum.
- out_sat, output, 1, present only with AP_ACC_SAT_FLAG_EN (see Optional Feature).

Behaviour:
- Reset: asynchronous on rst_n low. acc=0, count=0, state=ACCUM, out_valid=0, out_data=0, in_ready=1 once rst_n is released (in_ready=0 while rst_n is low).
- Saturating step, with a = acc and x = in_data:
  - s = a + x, wrapped to BITLENGTH bits.
  - If a>0 and x>0 and s≤0, then s=INF.
  - Else if a<0 and x<0 and s≥0, then s=-INF.
  - Otherwise s stands unchanged. The most-negative code -2^(BITLENGTH-1) is a legal unclamped result; it is not forced to -INF.
  - Saturation is not sticky: later opposite-sign terms move the sum off the rail.
- FSM with two states:
  - ACCUM: in_ready=1, out_valid=0. On accept (in_valid & in_ready): acc←s, count←count+1.
    - If count==TERMS-1 at accept: out_data←s, acc←0, count←0, state→HOLD.
  - HOLD: in_ready=0, out_valid=1, out_data held stable. in_valid is ignored.
    - On out_ready: out_valid←0, state→ACCUM in the next cycle.
- Latency: out_valid rises on the clock edge that accepts the last operand; the result is visible in the cycle after that accept.
- Throughput: TERMS accepts plus at least one HOLD cycle per result. There is no accept in the cycle out_valid is dropped.
- clear:
  - Priority is rst_n > clear > handshakes.
  - Effect: acc←0, count←0, state→ACCUM, out_valid←0. Any pending result is discarded and any operand offered that cycle is dropped.
- TERMS=1: every accepted operand x produces out_data=x (0 plus x never clamps).
- Reset while in HOLD: out_valid falls immediately (asynchronously) and the result is lost.
- out_data keeps its last value after the handshake, until the next result is loaded.

Optional Feature:
- Macro: AP_ACC_SAT_FLAG_EN.
- Defined:
  - Port out_sat exists.
  - An internal sticky flag sets whenever any step of the current sum clamps to ±INF.
  - The flag is copied to out_sat when the result loads into HOLD.
  - out_sat is valid only while out_valid=1.
  - The flag is cleared by reset, clear, and the start of each new sum.
- Undefined: no out_sat port and no flag logic; datapath behaviour is identical.

Test Plan (BITLENGTH=12, INF=2047, TERMS=4):
- Operands 100, 200, -50, 7 back-to-back, out_ready=1 → out_valid for 1 cycle, out_data=257, out_sat=0.
- Operands 1500, 1000, -100, 10 → steps 2047, 1947, 1957; out_data=1957; out_sat=1 (clamp is not sticky).
- Operands -1500, -1000, -1, -1 → steps -2047, -2048 (legal, no clamp), then wrap → -2047; out_data=-2047, out_sat=1.
- Result pending with out_ready=0 for 5 cycles while in_valid=1 → out_data stable, in_ready=0, no operand consumed; next sum starts after out_ready=1.
- Two operands (5, 6) accepted, clear pulsed, then 1, 2, 3, 4 → out_data=10 (not 21), out_sat=0.
- rst_n pulsed low while in HOLD → out_valid=0 asynchronously; after release, 4, 4, 4, 4 → out_data=16.

Source files
------------

// File: rtl/ap_accumulator.sv
// Streaming saturating accumulator: sums TERMS signed operands with clamp-to-+/-INF at every step.
// Optional sticky-saturation output out_sat is enabled with `define AP_ACC_SAT_FLAG_EN.
module ap_accumulator #(
  parameter int BITLENGTH = 12,
  parameter int INF       = 2**(BITLENGTH-1) - 1,
  parameter int TERMS     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [BITLENGTH-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [BITLENGTH-1:0] out_data
`ifdef AP_ACC_SAT_FLAG_EN
  ,
  output logic                        out_sat
`endif
);

  localparam int CW = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TERMS - 1);
  localparam logic signed [BITLENGTH-1:0] POS_RAIL = BITLENGTH'(INF);
  localparam logic signed [BITLENGTH-1:0] NEG_RAIL = -POS_RAIL;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                        state_q;
  logic signed [BITLENGTH-1:0]   acc_q;
  logic        [CW-1:0]          count_q;
  logic                          out_valid_q;
  logic signed [BITLENGTH-1:0]   out_data_q;
  logic signed [BITLENGTH-1:0]   sum_raw;
  logic signed [BITLENGTH-1:0]   sum_d;
  logic                          clamp_pos;
  logic                          clamp_neg;
  logic                          clamp;
  logic                          accept;

  // Overflow is detected from operand/result signs; the most-negative code is a legal result.
  always_comb begin
    sum_raw   = acc_q + in_data;
    clamp_pos = !acc_q[BITLENGTH-1] && (acc_q != '0) &&
                !in_data[BITLENGTH-1] && (in_data != '0) &&
                (sum_raw[BITLENGTH-1] || (sum_raw == '0));
    clamp_neg = acc_q[BITLENGTH-1] && in_data[BITLENGTH-1] && !sum_raw[BITLENGTH-1];
    clamp     = clamp_pos || clamp_neg;
    sum_d     = sum_raw;
    if (clamp_pos) begin
      sum_d = POS_RAIL;
    end else if (clamp_neg) begin
      sum_d = NEG_RAIL;
    end
  end

  // rst_n gates in_ready so the block advertises nothing while held in reset.
  assign in_ready  = rst_n && (state_q == ACCUM);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef AP_ACC_SAT_FLAG_EN
  logic sat_q;
  logic out_sat_q;
  assign out_sat = out_sat_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef AP_ACC_SAT_FLAG_EN
      sat_q       <= 1'b0;
      out_sat_q   <= 1'b0;
`endif
    end else if (clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef AP_ACC_SAT_FLAG_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (count_q == LAST) begin
              out_data_q  <= sum_d;
              acc_q       <= '0;
              count_q     <= '0;
              out_valid_q <= 1'b1;
              state_q     <= HOLD;
`ifdef AP_ACC_SAT_FLAG_EN
              out_sat_q   <= sat_q || clamp;
              sat_q       <= 1'b0;
`endif
            end else begin
              acc_q   <= sum_d;
              count_q <= count_q + CW'(1);
`ifdef AP_ACC_SAT_FLAG_EN
              sat_q   <= sat_q || clamp;
`endif
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_accumulator.sv
// Scoreboard bench for ap_accumulator (BITLENGTH=12, TERMS=4): driver pushes model results, monitor pops on handshake.
module tb_ap_accumulator;

  localparam int BL    = 12;
  localparam int INF   = 2047;
  localparam int TERMS = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [BL-1:0] in_data = '0;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [BL-1:0] out_data;
`ifdef AP_ACC_SAT_FLAG_EN
  logic                 out_sat;
`endif

  ap_accumulator #(.BITLENGTH(BL), .INF(INF), .TERMS(TERMS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef AP_ACC_SAT_FLAG_EN
    ,
    .out_sat   (out_sat)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];
  bit expsat_q[$];
  int pushed = 0;
  int popped = 0;
  int m_sum = 0;
  int m_cnt = 0;
  bit m_sat = 1'b0;
  int ordy_mode = 1;  // 0 random, 1 hold low, 2 hold high

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer sum, then clamp by the overflow rule (-2048 itself is legal).
  function automatic int ref_step(input int a, input int x, output bit clamped);
    int t;
    t = a + x;
    clamped = 1'b0;
    if (t > INF) begin
      t = INF; clamped = 1'b1;
    end else if (t < -INF - 1) begin
      t = -INF; clamped = 1'b1;
    end
    return t;
  endfunction

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_sat = 1'b0;
  endtask

  task automatic send(input int x);
    int n;
    bit c;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = BL'(x);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    m_sum = ref_step(m_sum, x, c);
    m_sat = m_sat | c;
    m_cnt++;
    if (m_cnt == TERMS) begin
      exp_q.push_back(m_sum);
      expsat_q.push_back(m_sat);
      pushed++;
      model_reset();
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares on every accepted result and checks out_data holds while stalled.
  initial begin
    logic signed [BL-1:0] held;
    bit held_v;
    int e;
    bit es;
    held = '0;
    held_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (held_v) chk("hold_stable", int'(out_data), int'(held));
        held = out_data;
        held_v = 1'b1;
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            e  = exp_q.pop_front();
            es = expsat_q.pop_front();
            popped++;
            chk("out_data", int'(out_data), e);
`ifdef AP_ACC_SAT_FLAG_EN
            chk("out_sat", int'(out_sat), int'(es));
`endif
          end
          held_v = 1'b0;
        end
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_data", int'(out_data), 0);
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);

    ordy_mode = 2;
    send(100); send(200); send(-50); send(7);
    send(1500); send(1000); send(-100); send(10);
    send(-1500); send(-1000); send(-1); send(-1);
    wait_drain();

    ordy_mode = 1;
    @(posedge clk);
    send(300); send(-20); send(45); send(-5);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = BL'(99);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_out_valid", int'(out_valid), 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    ordy_mode = 2;
    send(1); send(1); send(1); send(1);

    send(5); send(6);
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = BL'(77);
    @(posedge clk);
    #1 clear = 1'b0;
    in_valid = 1'b0;
    model_reset();
    send(1); send(2); send(3); send(4);
    wait_drain();

    ordy_mode = 1;
    @(posedge clk);
    #2;
    send(500); send(600); send(-7); send(8);
    wait_valid();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", int'(out_valid), 0);
    chk("async_rst_in_ready", int'(in_ready), 0);
    chk("async_rst_out_data", int'(out_data), 0);
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_back());
      void'(expsat_q.pop_back());
      pushed--;
    end
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    ordy_mode = 2;
    @(negedge clk);
    chk("rerelease_in_ready", int'(in_ready), 1);
    send(4); send(4); send(4); send(4);

    ordy_mode = 0;
    for (int s = 0; s < 40; s++) begin
      for (int k = 0; k < TERMS; k++) begin
        int x;
        if ($urandom_range(0, 2) == 0) x = int'($urandom_range(0, 200)) - 100;
        else x = int'($urandom_range(0, 4095)) - 2048;
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        send(x);
      end
    end
    ordy_mode = 2;
    wait_drain();
    chk("result_count", popped, pushed);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
